// File: rtl/square_share_if.sv
// Request/response bundle between four requesters and the shared squarer.
interface square_share_if;
    logic [3:0] req;
    logic [7:0] din;
    logic [3:0] ack;
    logic [3:0] dout;
    logic [1:0] dout_id;
    logic       valid;
    logic       busy;
    logic [7:0] done_cnt;

    modport master (
        output req, din,
        input  ack, dout, dout_id, valid, busy, done_cnt
    );

    modport slave (
        input  req, din,
        output ack, dout, dout_id, valid, busy, done_cnt
    );
endinterface

// File: rtl/square_share_ctrl.sv
// Round-robin arbiter sharing one 2-bit squarer among four requesters.
// Each operation walks IDLE -> COMPUTE -> RESP, giving one result per 3 cycles.
module square_share_ctrl (
    input  logic           clk,
    input  logic           rst,
    square_share_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] grant;
    logic [1:0] operand;
    logic [3:0] dout_q;
    logic [1:0] dout_id_q;
    logic [7:0] done_cnt_q;

    logic [1:0] pick;
    logic [1:0] idx;

    function automatic logic [3:0] square2(input logic [1:0] x);
        case (x)
            2'd0:    square2 = 4'b0000;
            2'd1:    square2 = 4'b0001;
            2'd2:    square2 = 4'b0100;
            default: square2 = 4'b1001;
        endcase
    endfunction

    // Descending scan so the requester closest to ptr overwrites the others.
    always_comb begin
        pick = ptr;
        idx  = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (bus.req[idx]) begin
                pick = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            grant      <= 2'd0;
            operand    <= 2'd0;
            dout_q     <= 4'd0;
            dout_id_q  <= 2'd0;
            done_cnt_q <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != 4'd0) begin
                        grant   <= pick;
                        ptr     <= pick + 2'd1;
                        operand <= bus.din[{pick, 1'b0} +: 2];
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    dout_q    <= square2(operand);
                    dout_id_q <= grant;
                    // Count lands with the RESP cycle so it is visible alongside valid.
                    if (done_cnt_q != 8'hFF) begin
                        done_cnt_q <= done_cnt_q + 8'd1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.valid    = (state == RESP);
    assign bus.busy     = (state != IDLE);
    assign bus.ack      = (state == RESP) ? (4'b0001 << dout_id_q) : 4'b0000;
    assign bus.dout     = dout_q;
    assign bus.dout_id  = dout_id_q;
    assign bus.done_cnt = done_cnt_q;

endmodule

// File: tb/tb_square_share_ctrl.sv
// Directed bench for square_share_ctrl; expected values are hand-computed.
module tb_square_share_ctrl;

    logic clk;
    logic rst;
    int   check_count;
    int   error_count;

    square_share_if bus ();

    square_share_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] d);
        bus.req = r;
        bus.din = d;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkResp(input string tag, input logic [1:0] id, input logic [3:0] sq);
        checkOutput({tag, "_valid"}, 8'(bus.valid), 8'd1);
        checkOutput({tag, "_ack"}, 8'(bus.ack), 8'(4'b0001 << id));
        checkOutput({tag, "_dout"}, 8'(bus.dout), 8'(sq));
        checkOutput({tag, "_id"}, 8'(bus.dout_id), 8'(id));
    endtask

    // Requester i carries operand i in din=E4, so its square is i*i.
    logic [3:0] sq_by_id [4] = '{4'd0, 4'd1, 4'd4, 4'd9};
    logic [1:0] fair_ids [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [3:0] fair_sq  [4] = '{4'd4, 4'd9, 4'd4, 4'd9};

    initial begin
        check_count = 0;
        error_count = 0;
        rst = 1'b1;
        applyStimulus(4'b0000, 8'h00);
        step(2);

        checkOutput("rst_ack", 8'(bus.ack), 8'd0);
        checkOutput("rst_valid", 8'(bus.valid), 8'd0);
        checkOutput("rst_dout", 8'(bus.dout), 8'd0);
        checkOutput("rst_id", 8'(bus.dout_id), 8'd0);
        checkOutput("rst_cnt", bus.done_cnt, 8'd0);
        checkOutput("rst_busy", 8'(bus.busy), 8'd0);

        // Single request from requester 0 with operand 3
        rst = 1'b0;
        applyStimulus(4'b0001, 8'h03);
        step(1);
        checkOutput("single_busy", 8'(bus.busy), 8'd1);
        checkOutput("single_novalid", 8'(bus.valid), 8'd0);
        step(1);
        checkResp("single", 2'd0, 4'b1001);
        checkOutput("single_cnt", bus.done_cnt, 8'd1);
        applyStimulus(4'b0000, 8'h03);
        step(1);
        checkOutput("single_after_valid", 8'(bus.valid), 8'd0);
        checkOutput("single_after_ack", 8'(bus.ack), 8'd0);
        checkOutput("single_after_busy", 8'(bus.busy), 8'd0);
        checkOutput("single_hold_dout", 8'(bus.dout), 8'h09);

        // All four requesting; each drops its bit after its ack
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        applyStimulus(4'b1111, 8'hE4);
        for (int i = 0; i < 4; i++) begin
            step(2);
            checkResp($sformatf("all%0d", i), 2'(i), sq_by_id[i]);
            bus.req[i] = 1'b0;
            step(1);
            checkOutput($sformatf("all%0d_idle_valid", i), 8'(bus.valid), 8'd0);
            checkOutput($sformatf("all%0d_idle_busy", i), 8'(bus.busy), 8'd0);
        end
        checkOutput("all_cnt", bus.done_cnt, 8'd4);

        // Requesters 0 and 2 held continuously must alternate
        applyStimulus(4'b0101, 8'h32);
        for (int k = 0; k < 4; k++) begin
            step(2);
            checkResp($sformatf("fair%0d", k), fair_ids[k], fair_sq[k]);
            if (k == 3) begin
                applyStimulus(4'b0000, 8'h32);
            end
            step(1);
        end
        checkOutput("fair_cnt", bus.done_cnt, 8'd8);

        // Reset while in COMPUTE aborts the operation
        applyStimulus(4'b0001, 8'h02);
        step(1);
        checkOutput("abort_busy", 8'(bus.busy), 8'd1);
        rst = 1'b1;
        applyStimulus(4'b0000, 8'h00);
        step(1);
        checkOutput("abort_valid", 8'(bus.valid), 8'd0);
        checkOutput("abort_ack", 8'(bus.ack), 8'd0);
        checkOutput("abort_dout", 8'(bus.dout), 8'd0);
        checkOutput("abort_id", 8'(bus.dout_id), 8'd0);
        checkOutput("abort_cnt", bus.done_cnt, 8'd0);
        checkOutput("abort_busy0", 8'(bus.busy), 8'd0);
        rst = 1'b0;
        applyStimulus(4'b1000, 8'hC0);
        step(1);
        checkOutput("abort_new_noack", 8'(bus.ack), 8'd0);
        step(1);
        checkResp("abort_new", 2'd3, 4'b1001);
        checkOutput("abort_new_cnt", bus.done_cnt, 8'd1);
        applyStimulus(4'b0000, 8'hC0);
        step(1);

        // Withdrawal and operand change during COMPUTE use the latched value
        applyStimulus(4'b0001, 8'h02);
        step(1);
        applyStimulus(4'b0000, 8'h03);
        step(1);
        checkResp("withdraw", 2'd0, 4'b0100);
        checkOutput("withdraw_cnt", bus.done_cnt, 8'd2);
        step(1);

        // Counter saturation over 260+ completions
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        applyStimulus(4'b0001, 8'h03);
        step(762);
        checkOutput("sat_254", bus.done_cnt, 8'd254);
        step(10);
        checkOutput("sat_255", bus.done_cnt, 8'd255);
        step(30);
        checkOutput("sat_hold", bus.done_cnt, 8'd255);
        applyStimulus(4'b0000, 8'h00);
        step(3);
        checkOutput("sat_final", bus.done_cnt, 8'd255);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
